// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock keypad-entry logic.
//   - key codes for the command keys (digits are 0-9)
//   - state encoding of the entry controller
//   - BCD limits and a helper that checks a buffered HH:MM for legality
package clock_pkg;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    localparam logic [3:0] MAX_MS_HR      = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN     = 4'd5;
    localparam logic [3:0] MAX_BCD        = 4'd9;

    typedef enum logic [1:0] {
        ST_SHOW_TIME  = 2'd0,
        ST_ENTRY      = 2'd1,
        ST_SHOW_ALARM = 2'd2
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= MAX_BCD;
    endfunction

    // 00:00 .. 23:59; hour tens of 2 limits the hour units to 0-3
    function automatic logic valid_hhmm(input logic [3:0] ms_hr, input logic [3:0] ls_hr,
                                        input logic [3:0] ms_min, input logic [3:0] ls_min);
        return (ms_hr <= MAX_MS_HR) &&
               ((ms_hr != MAX_MS_HR) || (ls_hr <= MAX_LS_HR_AT_2)) &&
               (ls_hr <= MAX_BCD) &&
               (ms_min <= MAX_MS_MIN) &&
               (ls_min <= MAX_BCD);
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Four-digit BCD entry buffer with a saturating digit count.
//   clock, reset : posedge clock, synchronous active-high reset
//   load         : buffer <= {0,0,0,din}, count <= 1 (first digit of an entry)
//   shift        : shift din in at the minute-units end, count saturates at 4
//   clear        : buffer and count to zero
//   din          : BCD digit to load/shift
//   ms_hr..ls_min: buffered digits, hour tens first
//   count        : number of digits entered, 0-4
// Priority: reset/clear, then load, then shift; otherwise hold.
module key_shift_reg (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic       clear,
    input  logic [3:0] din,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [2:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            ms_hr  <= 4'd0;
            ls_hr  <= 4'd0;
            ms_min <= 4'd0;
            ls_min <= 4'd0;
            count  <= 3'd0;
        end else if (load) begin
            ms_hr  <= 4'd0;
            ls_hr  <= 4'd0;
            ms_min <= 4'd0;
            ls_min <= din;
            count  <= 3'd1;
        end else if (shift) begin
            // Last four keys win: older digits fall off the hour-tens end
            ms_hr  <= ls_hr;
            ls_hr  <= ms_min;
            ms_min <= ls_min;
            ls_min <= din;
            if (count < 3'd4) count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/alarm_entry_ctrl.sv
// Keypad-entry controller for the alarm clock.
// Collects four BCD digits, validates HH:MM on ALARM/TIME and issues a
// one-cycle load strobe (or entry_error), drives the display-select flags
// and aborts an idle entry after TIMEOUT_SEC one-second ticks.
//   clock, reset           : posedge clock, synchronous active-high reset
//   one_second             : 1 Hz single-cycle tick
//   key_valid, key         : key strobe and code (0-9, A alarm, B time, C clear)
//   new_alarm_*            : buffered digits (registered)
//   load_new_alarm/time    : commit strobes, aligned with the committed digits
//   show_new_time          : high while in ENTRY
//   show_alarm             : high while in SHOW_ALARM
//   entry_error            : rejected commit or entry timeout
module alarm_entry_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_SEC    = 10,
    parameter int SHOW_ALARM_SEC = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       entry_error
);

    localparam int TMAX = (TIMEOUT_SEC > SHOW_ALARM_SEC) ? TIMEOUT_SEC : SHOW_ALARM_SEC;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    // Tick counts at which the *next* tick reaches the limit
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_SEC - 1);
    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_ALARM_SEC - 1);

    entry_state_t  state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          buf_load, buf_shift, buf_clear;
    logic          la_nx, lt_nx, err_nx;
    logic [2:0]    count;
    logic          commit_ok;

    key_shift_reg u_buf (
        .clock  (clock),
        .reset  (reset),
        .load   (buf_load),
        .shift  (buf_shift),
        .clear  (buf_clear),
        .din    (key),
        .ms_hr  (new_alarm_ms_hr),
        .ls_hr  (new_alarm_ls_hr),
        .ms_min (new_alarm_ms_min),
        .ls_min (new_alarm_ls_min),
        .count  (count)
    );

    assign commit_ok = (count == 3'd4) &&
                       valid_hhmm(new_alarm_ms_hr, new_alarm_ls_hr,
                                  new_alarm_ms_min, new_alarm_ls_min);

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        buf_load  = 1'b0;
        buf_shift = 1'b0;
        buf_clear = 1'b0;
        la_nx     = 1'b0;
        lt_nx     = 1'b0;
        err_nx    = 1'b0;

        unique case (state)
            ST_SHOW_TIME: begin
                if (key_valid) begin
                    if (is_digit(key)) begin
                        buf_load = 1'b1;
                        timer_nx = '0;
                        state_nx = ST_ENTRY;
                    end else if (key == KEY_ALARM) begin
                        timer_nx = '0;
                        state_nx = ST_SHOW_ALARM;
                    end
                end
            end

            ST_ENTRY: begin
                // A key always wins over a coincident tick
                if (key_valid) begin
                    timer_nx = '0;
                    if (is_digit(key)) begin
                        buf_shift = 1'b1;
                    end else if (key == KEY_ALARM || key == KEY_TIME) begin
                        la_nx    = commit_ok && (key == KEY_ALARM);
                        lt_nx    = commit_ok && (key == KEY_TIME);
                        err_nx   = !commit_ok;
                        state_nx = ST_SHOW_TIME;
                    end else if (key == KEY_CLEAR) begin
                        buf_clear = 1'b1;
                        state_nx  = ST_SHOW_TIME;
                    end
                end else if (one_second) begin
                    if (timer == TIMEOUT_LAST) begin
                        err_nx   = 1'b1;
                        timer_nx = '0;
                        state_nx = ST_SHOW_TIME;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
            end

            ST_SHOW_ALARM: begin
                if (key_valid) begin
                    state_nx = ST_SHOW_TIME;
                end else if (one_second) begin
                    if (timer == SHOW_LAST) begin
                        timer_nx = '0;
                        state_nx = ST_SHOW_TIME;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
            end

            default: state_nx = ST_SHOW_TIME;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_SHOW_TIME;
            timer          <= '0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_error    <= 1'b0;
            show_new_time  <= 1'b0;
            show_alarm     <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            load_new_alarm <= la_nx;
            load_new_time  <= lt_nx;
            entry_error    <= err_nx;
            show_new_time  <= (state_nx == ST_ENTRY);
            show_alarm     <= (state_nx == ST_SHOW_ALARM);
        end
    end

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// Bench for alarm_entry_ctrl: directed key sequences followed by random
// keys/ticks/resets. A behavioural model predicts the outputs of every cycle
// and pushes them into a scoreboard queue; a monitor on the falling edge pops
// and compares them against the DUT.
module tb_alarm_entry_ctrl;

    localparam int TO_SEC = 10;
    localparam int SA_SEC = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_new_alarm, load_new_time, show_new_time, show_alarm, entry_error;

    alarm_entry_ctrl #(.TIMEOUT_SEC(TO_SEC), .SHOW_ALARM_SEC(SA_SEC)) dut (
        .clock            (clock),
        .reset            (reset),
        .one_second       (one_second),
        .key_valid        (key_valid),
        .key              (key),
        .new_alarm_ms_hr  (ms_hr),
        .new_alarm_ls_hr  (ls_hr),
        .new_alarm_ms_min (ms_min),
        .new_alarm_ls_min (ls_min),
        .load_new_alarm   (load_new_alarm),
        .load_new_time    (load_new_time),
        .show_new_time    (show_new_time),
        .show_alarm       (show_alarm),
        .entry_error      (entry_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [15:0] dig;
        logic [2:0] strb;   // {load_new_alarm, load_new_time, entry_error}
        logic [1:0] flg;    // {show_new_time, show_alarm}
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // ---------------- reference model ----------------
    // mode: 0 showing time, 1 entering digits, 2 showing alarm
    int m_mode = 0;
    int m_buf[4] = '{0, 0, 0, 0};
    int m_cnt = 0;
    int m_sec = 0;

    task automatic model(input logic r, input logic kv, input logic [3:0] k, input logic t);
        logic la, lt, err;
        int   hh, mm;
        exp_t e;
        la = 0; lt = 0; err = 0;
        if (r) begin
            m_mode = 0; m_buf = '{0, 0, 0, 0}; m_cnt = 0; m_sec = 0;
        end else if (m_mode == 0) begin
            if (kv && k <= 9) begin
                m_buf = '{0, 0, 0, int'(k)}; m_cnt = 1; m_sec = 0; m_mode = 1;
            end else if (kv && k == 4'hA) begin
                m_sec = 0; m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (kv) begin
                m_sec = 0;
                if (k <= 9) begin
                    m_buf = '{m_buf[1], m_buf[2], m_buf[3], int'(k)};
                    if (m_cnt < 4) m_cnt++;
                end else if (k == 4'hA || k == 4'hB) begin
                    hh = m_buf[0] * 10 + m_buf[1];
                    mm = m_buf[2] * 10 + m_buf[3];
                    if (m_cnt == 4 && hh <= 23 && mm <= 59) begin
                        la = (k == 4'hA); lt = (k == 4'hB);
                    end else begin
                        err = 1;
                    end
                    m_mode = 0;
                end else if (k == 4'hC) begin
                    m_buf = '{0, 0, 0, 0}; m_cnt = 0; m_mode = 0;
                end
            end else if (t) begin
                m_sec++;
                if (m_sec >= TO_SEC) begin
                    err = 1; m_mode = 0; m_sec = 0;
                end
            end
        end else begin
            if (kv) m_mode = 0;
            else if (t) begin
                m_sec++;
                if (m_sec >= SA_SEC) begin
                    m_mode = 0; m_sec = 0;
                end
            end
        end
        e.due  = cyc + 1;
        e.dig  = {4'(m_buf[0]), 4'(m_buf[1]), 4'(m_buf[2]), 4'(m_buf[3])};
        e.strb = {la, lt, err};
        e.flg  = {m_mode == 1, m_mode == 2};
        q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic kv, input logic [3:0] k, input logic t);
        @(posedge clock);
        #1;
        reset = r; key_valid = kv; key = k; one_second = t;
        model(r, kv, k, t);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 4'd0, 0);
    endtask

    task automatic press(input logic [3:0] k);
        step(0, 1, k, 0);
        idle(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(0, 0, 4'd0, 1);
            idle(1);
        end
    endtask

    task automatic press_seq(input logic [3:0] s[], input int len);
        for (int i = 0; i < len; i++) press(s[i]);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_checks++;
                if ({ms_hr, ls_hr, ms_min, ls_min} !== e.dig) begin
                    n_errors++;
                    $display("FAIL digits cyc=%0d got=%h exp=%h", cyc,
                             {ms_hr, ls_hr, ms_min, ls_min}, e.dig);
                end
                n_checks++;
                if ({load_new_alarm, load_new_time, entry_error} !== e.strb) begin
                    n_errors++;
                    $display("FAIL strobes(la,lt,err) cyc=%0d got=%b exp=%b", cyc,
                             {load_new_alarm, load_new_time, entry_error}, e.strb);
                end
                n_checks++;
                if ({show_new_time, show_alarm} !== e.flg) begin
                    n_errors++;
                    $display("FAIL flags(snt,sa) cyc=%0d got=%b exp=%b", cyc,
                             {show_new_time, show_alarm}, e.flg);
                end
            end
        end
    end

    initial begin
        logic [3:0] s[];
        int w;

        repeat (2) @(posedge clock);
        step(1, 0, 4'd0, 0);
        step(1, 1, 4'd5, 1);            // reset overrides key and tick
        idle(2);

        s = new[5]; s = '{4'd1, 4'd1, 4'd4, 4'd5, 4'hA}; press_seq(s, 5); idle(2);
        s = '{4'd2, 4'd4, 4'd0, 4'd0, 4'hB};              press_seq(s, 5); idle(1);
        s = '{4'd2, 4'd3, 4'd5, 4'd9, 4'hB};              press_seq(s, 5); idle(1);
        s = new[7]; s = '{4'd1, 4'd6, 4'd3, 4'd2, 4'd0, 4'd7, 4'hA}; press_seq(s, 7);
        s = new[3]; s = '{4'd0, 4'd4, 4'hA};              press_seq(s, 3); idle(1);

        press(4'd0); ticks(TO_SEC); idle(1);                   // timeout
        press(4'd0); ticks(TO_SEC - 2); step(0, 1, 4'd4, 1);   // key with tick 9
        idle(1); ticks(1); ticks(TO_SEC - 1);                  // no timeout at 10, then expires
        press(4'hA); ticks(SA_SEC); idle(1);
        press(4'hA); ticks(2); press(4'd7); idle(1);
        s = '{4'd0, 4'd4, 4'd3}; press_seq(s, 3);
        step(1, 0, 4'd0, 0); idle(1);
        press(4'hA); ticks(SA_SEC);
        s = new[4]; s = '{4'd1, 4'd2, 4'hD, 4'hC}; press_seq(s, 4); idle(1);

        // random: busy typing, then sparse keys so timeouts occur
        for (int i = 0; i < 4000; i++) begin
            logic kv, t, r;
            logic [3:0] k;
            w  = (i < 2000) ? 35 : 4;
            kv = ($urandom_range(0, 99) < w);
            t  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 499) == 0);
            k  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9))
                                             : 4'($urandom_range(10, 15));
            step(r, kv, k, t);
        end
        idle(3);

        // bounded drain of the scoreboard
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
